// File: rtl/mem_bus_arbiter_if.sv
// Request/response and memory-side signals shared by the CPU/DMA memory arbiter.
// The slave view is the arbiter; the master view is the requesters plus the memory.
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic                  cpu_err;

    logic                  dma_req;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic                  dma_gnt;
    logic                  dma_rvalid;
    logic                  dma_err;

    logic [DATA_WIDTH-1:0] rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_err,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_err,
        output rdata,
        output mem_addr, mem_read, mem_write, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_err,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_err,
        input  rdata,
        input  mem_addr, mem_read, mem_write, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester (CPU/DMA) arbiter for a synchronous single-port memory.
// Three-stage pipeline ACCEPT -> ACCESS -> RESPONSE with a write-protected ROM region.
module mem_bus_arbiter #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    STARVE_LIMIT = 4,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE     = 16'hF000
) (
    input logic               clk,
    input logic               reset,
    mem_bus_arbiter_if.slave  bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= LIMIT) ? LIMIT : v + 4'd1;
    endfunction

    logic [3:0]            starve_cnt;
    logic                  dma_win;
    logic                  cpu_acc;
    logic                  dma_acc;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;

    logic                  vld_p1;
    logic                  we_p1;
    logic                  own_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [DATA_WIDTH-1:0] wdata_p1;
    logic                  vld_p2;
    logic                  own_p2;
    logic                  rom_hit_p1;
    logic                  wr_err_p1;

    // ACCEPT: CPU has priority unless DMA has lost STARVE_LIMIT conflicts in a row
    assign dma_win = bus.dma_req && (!bus.cpu_req || starve_cnt == LIMIT);
    assign dma_acc = !reset && dma_win;
    assign cpu_acc = !reset && bus.cpu_req && !dma_win;

    assign bus.cpu_gnt = cpu_acc;
    assign bus.dma_gnt = dma_acc;

    always_comb begin
        acc_we    = bus.cpu_we;
        acc_addr  = bus.cpu_addr;
        acc_wdata = bus.cpu_wdata;
        if (dma_win) begin
            acc_we    = bus.dma_we;
            acc_addr  = bus.dma_addr;
            acc_wdata = bus.dma_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            vld_p1     <= 1'b0;
            we_p1      <= 1'b0;
            own_p1     <= 1'b0;
            addr_p1    <= '0;
            wdata_p1   <= '0;
            vld_p2     <= 1'b0;
            own_p2     <= 1'b0;
        end else begin
            if (dma_acc) begin
                starve_cnt <= '0;
            end else if (bus.cpu_req && bus.dma_req) begin
                starve_cnt <= sat_inc(starve_cnt);
            end

            vld_p1 <= cpu_acc || dma_acc;
            if (cpu_acc || dma_acc) begin
                own_p1  <= dma_acc;
                we_p1   <= acc_we;
                addr_p1 <= acc_addr;
                // Write data only moves on writes so mem_wdata stays put across reads
                if (acc_we) begin
                    wdata_p1 <= acc_wdata;
                end
            end

            vld_p2 <= vld_p1 && !we_p1;
            own_p2 <= own_p1;
        end
    end

    // ACCESS: memory strobes decoded from the registered request
    assign rom_hit_p1    = addr_p1 >= ROM_BASE;
    assign wr_err_p1     = vld_p1 && we_p1 && rom_hit_p1;
    assign bus.mem_read  = vld_p1 && !we_p1;
    assign bus.mem_write = vld_p1 && we_p1 && !rom_hit_p1;
    assign bus.mem_addr  = addr_p1;
    assign bus.mem_wdata = wdata_p1;
    assign bus.cpu_err   = wr_err_p1 && !own_p1;
    assign bus.dma_err   = wr_err_p1 && own_p1;

    // RESPONSE: read data passes straight through to the recorded owner
    assign bus.cpu_rvalid = vld_p2 && !own_p2;
    assign bus.dma_rvalid = vld_p2 && own_p2;
    assign bus.rdata      = vld_p2 ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then
// randomized CPU/DMA traffic checked every cycle against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam int          LIMIT = 4;
    localparam logic [15:0] ROM   = 16'hF000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

    mem_bus_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .STARVE_LIMIT(LIMIT), .ROM_BASE(ROM)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // Synchronous memory: read data appears the cycle after mem_read
    logic [7:0] mem [0:65535];
    logic [7:0] mem_q = 8'h00;
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_read) mem_q <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = mem_q;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Transaction-level reference: each accepted request is stamped with its accept cycle;
    // the access happens one cycle later and a read answers two cycles later.
    typedef struct {
        int          cyc;
        bit          dma;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rd;
    } txn_t;

    txn_t        q[$];
    logic [7:0]  mmem [0:65535];
    int          cyc = 0;
    int          starve = 0;
    bit          mg_cpu = 0, mg_dma = 0;
    logic [15:0] last_addr = '0;
    logic [7:0]  last_wdata = '0;
    int          exp_rv = 0, act_rv = 0;
    bit          e_cpu, e_dma, e_rd, e_wr, e_cerr, e_derr, e_crv, e_drv;
    logic [7:0]  e_rdata;
    txn_t        t;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("reset_ctrl", {bus.cpu_gnt, bus.dma_gnt, bus.cpu_rvalid, bus.dma_rvalid,
                               bus.cpu_err, bus.dma_err, bus.mem_read, bus.mem_write}, 0);
            chk("reset_data", {bus.mem_addr, bus.mem_wdata, bus.rdata}, 0);
            q.delete();
            starve = 0;
            mg_cpu = 0;
            mg_dma = 0;
            last_addr = '0;
            last_wdata = '0;
        end else begin
            e_dma = bus.dma_req && (!bus.cpu_req || starve == LIMIT);
            e_cpu = bus.cpu_req && !e_dma;
            {e_rd, e_wr, e_cerr, e_derr, e_crv, e_drv} = '0;
            e_rdata = 8'h00;
            foreach (q[i]) begin
                if (q[i].cyc == cyc - 1) begin
                    last_addr = q[i].addr;
                    if (!q[i].we) begin
                        e_rd = 1;
                        q[i].rd = mmem[q[i].addr];
                    end else begin
                        last_wdata = q[i].wdata;
                        if (q[i].addr < ROM) begin
                            e_wr = 1;
                            mmem[q[i].addr] = q[i].wdata;
                        end else if (q[i].dma) e_derr = 1;
                        else e_cerr = 1;
                    end
                end else if (q[i].cyc == cyc - 2 && !q[i].we) begin
                    if (q[i].dma) e_drv = 1;
                    else e_crv = 1;
                    e_rdata = q[i].rd;
                end
            end

            chk("gnt", {bus.cpu_gnt, bus.dma_gnt}, {e_cpu, e_dma});
            chk("access", {bus.mem_read, bus.mem_write, bus.cpu_err, bus.dma_err},
                {e_rd, e_wr, e_cerr, e_derr});
            chk("mem_addr", bus.mem_addr, last_addr);
            chk("mem_wdata", bus.mem_wdata, last_wdata);
            chk("rvalid", {bus.cpu_rvalid, bus.dma_rvalid}, {e_crv, e_drv});
            chk("rdata", bus.rdata, e_rdata);
            chk("gnt_onehot", !(bus.cpu_gnt && bus.dma_gnt), 1);
            chk("rvalid_onehot", !(bus.cpu_rvalid && bus.dma_rvalid), 1);
            chk("rd_wr_excl", !(bus.mem_read && bus.mem_write), 1);

            exp_rv += int'(e_crv) + int'(e_drv);
            act_rv += int'(bus.cpu_rvalid) + int'(bus.dma_rvalid);

            if (e_cpu || e_dma) begin
                t.cyc   = cyc;
                t.dma   = e_dma;
                t.we    = e_dma ? bus.dma_we : bus.cpu_we;
                t.addr  = e_dma ? bus.dma_addr : bus.cpu_addr;
                t.wdata = e_dma ? bus.dma_wdata : bus.cpu_wdata;
                t.rd    = 8'h00;
                q.push_back(t);
            end
            if (e_dma) starve = 0;
            else if (bus.cpu_req && bus.dma_req && starve < LIMIT) starve++;
            mg_cpu = e_cpu;
            mg_dma = e_dma;
            while (q.size() > 0 && q[0].cyc < cyc - 1) void'(q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit dma, input bit req, input bit we,
                       input logic [15:0] a, input logic [7:0] d);
        if (dma) begin
            bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
        end else begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom % 6)
            0: return 16'hEFFF;
            1: return 16'hF000;
            2: return 16'hFFFF;
            3: return 16'h0100 + 16'($urandom % 8);
            4: return 16'hEFF8 + 16'($urandom % 16);
            default: return 16'($urandom);
        endcase
    endfunction

    logic [15:0] wa [4];
    bit          we_err [4];
    bit          c_act, d_act, c_we, d_we;
    logic [15:0] c_addr, d_addr;
    logic [7:0]  c_wd, d_wd;

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a]  = init_val(16'(a));
            mmem[a] = init_val(16'(a));
        end
        mem[16'hF000]  = 8'hA5;
        mmem[16'hF000] = 8'hA5;
        drv(0, 0, 0, 16'h0, 8'h0);
        drv(1, 0, 0, 16'h0, 8'h0);

        repeat (3) tick();
        // Requests during reset must not be granted
        drv(0, 1, 0, 16'hF000, 8'h00);
        #1;
        chk("reset_no_gnt", bus.cpu_gnt, 0);
        chk("reset_mem_addr", bus.mem_addr, 16'h0000);

        // CPU read of F000 accepted on the first edge after release
        tick();
        reset = 0;
        #1;
        chk("d33_gnt", {bus.cpu_gnt, bus.dma_gnt}, 2'b10);
        tick();
        drv(0, 0, 0, 16'h0, 8'h0);
        #1;
        chk("d33_access", {bus.mem_read, bus.mem_write, bus.mem_addr}, {2'b10, 16'hF000});
        tick();
        #1;
        chk("d33_resp", {bus.cpu_rvalid, bus.dma_rvalid, bus.rdata}, {2'b10, 8'hA5});
        tick();

        // Continuous conflict: DMA wins every 5th cycle
        for (int k = 0; k < 10; k++) begin
            drv(0, 1, 0, 16'h0200 + 16'(k), 8'h0);
            drv(1, 1, 0, 16'h0300 + 16'(k), 8'h0);
            #1;
            chk("d34_gnt", {bus.cpu_gnt, bus.dma_gnt}, {k % 5 != 4, k % 5 == 4});
            tick();
        end
        drv(0, 0, 0, 16'h0, 8'h0);
        drv(1, 0, 0, 16'h0, 8'h0);
        repeat (2) tick();

        // DMA write 3C to 0100, CPU read-back right behind it
        drv(1, 1, 1, 16'h0100, 8'h3C);
        #1;
        chk("d35_dgnt", bus.dma_gnt, 1);
        tick();
        drv(1, 0, 0, 16'h0, 8'h0);
        drv(0, 1, 0, 16'h0100, 8'h00);
        #1;
        chk("d35_cgnt", bus.cpu_gnt, 1);
        chk("d35_write", {bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata},
            {2'b10, 16'h0100, 8'h3C});
        tick();
        drv(0, 0, 0, 16'h0, 8'h0);
        #1;
        chk("d35_read", {bus.mem_read, bus.mem_write, bus.mem_addr}, {2'b10, 16'h0100});
        tick();
        #1;
        chk("d35_resp", {bus.cpu_rvalid, bus.rdata}, {1'b1, 8'h3C});
        tick();

        // Write-protect boundary
        wa[0] = 16'hEFFF; we_err[0] = 0;
        wa[1] = 16'hF000; we_err[1] = 1;
        wa[2] = 16'hF001; we_err[2] = 1;
        wa[3] = 16'hFFFF; we_err[3] = 1;
        for (int i = 0; i < 4; i++) begin
            drv(0, 1, 1, wa[i], 8'h55);
            #1;
            chk("d36_gnt", bus.cpu_gnt, 1);
            tick();
            drv(0, 0, 0, 16'h0, 8'h0);
            #1;
            chk("d36_access", {bus.cpu_err, bus.mem_write, bus.dma_err},
                {we_err[i], !we_err[i], 1'b0});
            if (!we_err[i]) chk("d36_addr", bus.mem_addr, wa[i]);
            tick();
            #1;
            chk("d36_after", {bus.cpu_err, bus.cpu_rvalid, bus.mem_write}, 3'b000);
        end
        tick();

        // Reset during the ACCESS cycle of a CPU read
        drv(0, 1, 0, 16'h0100, 8'h00);
        #1;
        chk("d37_gnt", bus.cpu_gnt, 1);
        tick();
        drv(0, 0, 0, 16'h0, 8'h0);
        #1;
        chk("d37_access", bus.mem_read, 1);
        reset = 1;
        #1;
        chk("d37_zero", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.rdata},
            0);
        repeat (2) tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("d37_no_rvalid", {bus.cpu_rvalid, bus.cpu_err}, 2'b00);
            tick();
        end
        drv(0, 1, 0, 16'h0100, 8'h00);
        #1;
        chk("d37_regnt", bus.cpu_gnt, 1);
        tick();
        drv(0, 0, 0, 16'h0, 8'h0);
        tick();
        #1;
        chk("d37_resp", {bus.cpu_rvalid, bus.rdata}, {1'b1, 8'h3C});
        tick();

        // Randomized traffic with withdrawals and occasional resets
        c_act = 0;
        d_act = 0;
        for (int k = 0; k < 3000; k++) begin
            if (reset) begin
                if ($urandom % 2 == 0) reset = 0;
            end else if ($urandom % 300 == 0) begin
                reset = 1;
                c_act = 0;
                d_act = 0;
            end
            if (c_act && mg_cpu) c_act = 0;
            else if (c_act && $urandom % 10 == 0) c_act = 0;
            if (d_act && mg_dma) d_act = 0;
            else if (d_act && $urandom % 10 == 0) d_act = 0;
            if (!c_act && !reset && $urandom % 100 < 55) begin
                c_act = 1; c_we = 1'($urandom); c_addr = rand_addr(); c_wd = 8'($urandom);
            end
            if (!d_act && !reset && $urandom % 100 < 55) begin
                d_act = 1; d_we = 1'($urandom); d_addr = rand_addr(); d_wd = 8'($urandom);
            end
            drv(0, c_act, c_we, c_addr, c_wd);
            drv(1, d_act, d_we, d_addr, d_wd);
            tick();
        end
        drv(0, 0, 0, 16'h0, 8'h0);
        drv(1, 0, 0, 16'h0, 8'h0);
        reset = 0;
        repeat (4) tick();
        chk("rvalid_count", act_rv, exp_rv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
